// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline control blocks: opcode constants,
// hazard-controller state encoding and register-use decode helpers.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED,
        ST_ERROR
    } hz_state_e;

    // Pipeline steering bundle, ordered as the controller's output ports.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic pipe_hold;
        logic control_sel;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      pipe_hold: 1'b0, control_sel: 1'b0};
    localparam hz_ctrl_t CTRL_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       pipe_hold: 1'b1, control_sel: 1'b0};
    localparam hz_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                        pipe_hold: 1'b0, control_sel: 1'b1};
    localparam hz_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         pipe_hold: 1'b0, control_sel: 1'b1};
    localparam hz_ctrl_t CTRL_BUBBLE_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                              pipe_hold: 1'b1, control_sel: 1'b1};

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return opcode inside {OP_LOAD, OP_ITYPE, OP_STORE, OP_BRANCH, OP_RTYPE};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return opcode inside {OP_STORE, OP_BRANCH, OP_RTYPE};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: load-use stalls, branch squash,
// data-memory waits with timeout, halt/drain, and saturating perf counters.
module hazard_controller
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             pipe_hold,
    output logic             control_sel,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    hz_state_e          state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    hz_ctrl_t           ctrl;
    logic               flush_evt;
    logic               load_use;
    logic               mem_stall;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((uses_rs1(id_opcode) && (ex_rd == id_rs1)) ||
                       (uses_rs2(id_opcode) && (ex_rd == id_rs2)));
    assign mem_stall = mem_req && !mem_ready;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl      = CTRL_RUN;
        flush_evt = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl = CTRL_HOLD;
                end else if (ex_branch_taken) begin
                    ctrl      = CTRL_FLUSH;
                    flush_evt = 1'b1;
                end else if (halt_req || load_use) begin
                    ctrl = CTRL_BUBBLE;
                end
            end
            ST_MEM_WAIT: if (!mem_ready) ctrl = CTRL_HOLD;
            ST_DRAIN:    ctrl = mem_stall ? CTRL_BUBBLE_HOLD : CTRL_BUBBLE;
            ST_HALTED:   ctrl = CTRL_BUBBLE;
            ST_ERROR:    ctrl = CTRL_BUBBLE_HOLD;
            default:     ctrl = CTRL_BUBBLE;
        endcase
        // Reset must bubble the decoder immediately, not after the next edge.
        if (!rst_n) begin
            ctrl      = CTRL_BUBBLE;
            flush_evt = 1'b0;
        end
    end

    assign {pc_write, if_id_write, if_id_flush, pipe_hold, control_sel} = ctrl;
    assign halted    = (state == ST_HALTED);
    assign mem_error = (state == ST_ERROR);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else if (!ex_branch_taken && halt_req) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= ST_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt >= WAIT_LAST) state <= ST_ERROR;
                    end
                end
                ST_DRAIN: begin
                    // A stalled memory access keeps EX/MEM occupied, so the drain pauses.
                    if (!mem_stall) begin
                        if (drain_cnt <= DRAIN_W'(1)) state <= ST_HALTED;
                        else                          drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_HALTED: if (!halt_req) state <= ST_RUN;
                ST_ERROR:  state <= ST_ERROR;
                default:   state <= ST_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_evt),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller: RUN-state decode table plus
// hand sequences for memory wait, timeout, halt/drain, saturation and reset.
module tb_hazard_controller;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_mem_read, ex_branch_taken, mem_req, mem_ready, halt_req;
    logic             pc_write, if_id_write, if_id_flush, pipe_hold, control_sel;
    logic             halted, mem_error;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int vectors    = 0;
    int miscompares = 0;
    logic [CNT_W-1:0] exp_stall, exp_flush;

    // {pc_write, if_id_write, if_id_flush, pipe_hold, control_sel, halted, mem_error}
    logic [6:0] outs;
    assign outs = {pc_write, if_id_write, if_id_flush, pipe_hold, control_sel, halted, mem_error};

    hazard_controller #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_opcode       (id_opcode),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .halt_req        (halt_req),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .pipe_hold       (pipe_hold),
        .control_sel     (control_sel),
        .halted          (halted),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic mr, input logic [4:0] rd, input logic br,
                          input logic req, input logic rdy);
        id_opcode       = op;
        id_rs1          = rs1;
        id_rs2          = rs2;
        ex_mem_read     = mr;
        ex_rd           = rd;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
    endtask

    task automatic idle();
        set_in(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sample outputs mid-cycle, update the stall model, then step past the next rising edge.
    task automatic cycle(input string name, input logic [4:0] exp_ctrl, input logic [1:0] exp_flags);
        @(negedge clk);
        check(name, outs, {exp_ctrl, exp_flags});
        if (!exp_ctrl[4] && (exp_stall != '1)) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name);
        check({name, " stall_cycles"}, stall_cycles, exp_stall);
        check({name, " flush_count"}, flush_count, exp_flush);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        halt_req = 1'b0;
        idle();
        exp_stall = '0;
        exp_flush = '0;

        //          name            opcode      rs1 rs2 mr rd br req rdy exp
        tbl[0]  = '{"idle",         7'b0000000, 0,  0,  0, 0, 0, 0,  0, 5'b11000};
        tbl[1]  = '{"lu rtype rs2", 7'b0110011, 1,  5,  1, 5, 0, 0,  0, 5'b00001};
        tbl[2]  = '{"lu rd zero",   7'b0110011, 0,  0,  1, 0, 0, 0,  0, 5'b11000};
        tbl[3]  = '{"lu rtype rs1", 7'b0110011, 7,  3,  1, 7, 0, 0,  0, 5'b00001};
        tbl[4]  = '{"itype rs2 no", 7'b0010011, 1,  9,  1, 9, 0, 0,  0, 5'b11000};
        tbl[5]  = '{"lu load rs1",  7'b0000011, 4,  0,  1, 4, 0, 0,  0, 5'b00001};
        tbl[6]  = '{"lu store rs2", 7'b0100011, 2,  6,  1, 6, 0, 0,  0, 5'b00001};
        tbl[7]  = '{"lu branch",    7'b1100011, 10, 0,  1, 10, 0, 0, 0, 5'b00001};
        tbl[8]  = '{"jal no use",   7'b1101111, 5,  5,  1, 5, 0, 0,  0, 5'b11000};
        tbl[9]  = '{"no memread",   7'b0110011, 5,  0,  0, 5, 0, 0,  0, 5'b11000};
        tbl[10] = '{"branch",       7'b0000000, 0,  0,  0, 0, 1, 0,  0, 5'b11101};
        tbl[11] = '{"branch+lu",    7'b0110011, 8,  0,  1, 8, 1, 0,  0, 5'b11101};
        tbl[12] = '{"mem ready",    7'b0000000, 0,  0,  0, 0, 0, 1,  1, 5'b11000};
        tbl[13] = '{"mem rdy+lu",   7'b0110011, 0,  3,  1, 3, 0, 1,  1, 5'b00001};
        tbl[14] = '{"lui no use",   7'b0110111, 3,  3,  1, 3, 0, 0,  0, 5'b11000};

        // Reset values, asserted from time zero.
        #3;
        check("reset outs", outs, 7'b0000100);
        check("reset stall_cycles", stall_cycles, '0);
        check("reset flush_count", flush_count, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset outs held", outs, 7'b0000100);
        check("reset stall held", stall_cycles, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].opcode, tbl[i].rs1, tbl[i].rs2, tbl[i].mr, tbl[i].rd,
                   tbl[i].br, tbl[i].req, tbl[i].rdy);
            cycle(tbl[i].name, tbl[i].exp, 2'b00);
            if (tbl[i].br) exp_flush++;
        end
        idle();
        check_cnt("table");

        // Memory wait with a branch and halt present; both wait until release.
        set_in(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cycle("mw c1", 5'b00010, 2'b00);
        halt_req = 1'b1;
        cycle("mw c2", 5'b00010, 2'b00);
        cycle("mw c3", 5'b00010, 2'b00);
        halt_req = 1'b0;
        cycle("mw c4", 5'b00010, 2'b00);
        mem_ready = 1'b1;
        cycle("mw ready", 5'b11000, 2'b00);
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        cycle("mw branch after", 5'b11101, 2'b00);
        exp_flush++;
        idle();
        cycle("mw idle", 5'b11000, 2'b00);
        check_cnt("memwait");

        // Halt: three bubble cycles, then halted until halt_req drops.
        halt_req = 1'b1;
        cycle("halt b1", 5'b00001, 2'b00);
        cycle("halt b2", 5'b00001, 2'b00);
        cycle("halt b3", 5'b00001, 2'b00);
        cycle("halt h1", 5'b00001, 2'b10);
        cycle("halt h2", 5'b00001, 2'b10);
        halt_req = 1'b0;
        cycle("halt release", 5'b00001, 2'b10);
        cycle("halt run", 5'b11000, 2'b00);
        check_cnt("halt");

        // Halt with two stalled-memory cycles in the drain; halt_req drops mid-drain.
        halt_req = 1'b1;
        cycle("hs b1", 5'b00001, 2'b00);
        mem_req = 1'b1;
        cycle("hs stall1", 5'b00011, 2'b00);
        cycle("hs stall2", 5'b00011, 2'b00);
        mem_req = 1'b0;
        cycle("hs b4", 5'b00001, 2'b00);
        halt_req = 1'b0;
        cycle("hs b5", 5'b00001, 2'b00);
        cycle("hs halted", 5'b00001, 2'b10);
        cycle("hs run", 5'b11000, 2'b00);
        check_cnt("halt stall");

        // Timeout after eight wait cycles; error is sticky until reset.
        set_in(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) cycle($sformatf("to wait%0d", k), 5'b00010, 2'b00);
        cycle("to error", 5'b00011, 2'b01);
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        cycle("to sticky1", 5'b00011, 2'b01);
        cycle("to sticky2", 5'b00011, 2'b01);
        check_cnt("timeout");
        #2 rst_n = 1'b0;
        #1;
        check("to reset outs", outs, 7'b0000100);
        check("to reset stall", stall_cycles, '0);
        check("to reset flush", flush_count, '0);
        exp_stall = '0;
        exp_flush = '0;
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("to post reset", 5'b11000, 2'b00);

        // Flush counter saturation: 0xFFFF+2 taken branches.
        ex_branch_taken = 1'b1;
        cycle("sat br1", 5'b11101, 2'b00);
        exp_flush = 16'd1;
        check_cnt("sat first");
        repeat (65536) begin
            @(posedge clk);
            if (exp_flush != '1) exp_flush++;
        end
        #1;
        ex_branch_taken = 1'b0;
        check_cnt("sat end");
        cycle("sat idle", 5'b11000, 2'b00);
        check("sat hold", flush_count, 16'hFFFF);

        // Asynchronous reset in the middle of a drain.
        halt_req = 1'b1;
        cycle("rd b1", 5'b00001, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        check("rd reset outs", outs, 7'b0000100);
        check("rd reset stall", stall_cycles, '0);
        check("rd reset flush", flush_count, '0);
        exp_stall = '0;
        exp_flush = '0;
        halt_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("rd run", 5'b11000, 2'b00);
        check_cnt("rd final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
